// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: default FIFO depth, byte width and the
// RX-control status bit positions the controller maps the FIFO flags onto.
package uart_rx_fifo_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_DATA_BITS     = 8;

    // Bit positions inside the controller's RX-control/status register.
    localparam int RXSTAT_VALID_BIT   = 0;
    localparam int RXSTAT_OVERRUN_BIT = 1;
    localparam int RXSTAT_BREAK_BIT   = 2;
    localparam int RXSTAT_IRQ_BIT     = 3;
    localparam int RXSTAT_BITS        = 4;

    typedef struct packed {
        logic irq;
        logic break_det;
        logic overrun;
        logic valid;
    } rx_status_t;

    function automatic logic [RXSTAT_BITS-1:0] pack_rx_status(input rx_status_t s);
        logic [RXSTAT_BITS-1:0] w;
        w                     = '0;
        w[RXSTAT_VALID_BIT]   = s.valid;
        w[RXSTAT_OVERRUN_BIT] = s.overrun;
        w[RXSTAT_BREAK_BIT]   = s.break_det;
        w[RXSTAT_IRQ_BIT]     = s.irq;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_BITS register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART bit receiver and the register block: FWFT
// storage plus sticky overrun/break flags and a level-threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,
    parameter int DATA_BITS = UART_DATA_BITS,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    input  logic [DATA_BITS-1:0] i_in_data,
    input  logic                 i_in_break,
    input  logic                 i_pop,
    input  logic                 i_flush,
    input  logic                 i_stat_clr,
    input  logic [AW:0]          i_thresh,
    output logic [DATA_BITS-1:0] o_out_data,
    output logic                 o_out_valid,
    output logic [AW:0]          o_count,
    output logic                 o_full,
    output logic                 o_overrun,
    output logic                 o_break_det,
    output logic                 o_irq
);

    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic                 r_overrun;
    logic                 r_break_det;
    logic                 r_break_prev;
    logic                 r_irq;

    logic [AW:0]          w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_data_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_break_rise;
    logic [AW:0]          w_wr_ptr_nxt;
    logic [AW:0]          w_rd_ptr_nxt;
    logic [AW:0]          w_count_nxt;
    logic [DATA_BITS-1:0] w_rdata;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // A byte arriving during break is the break character, never data.
    assign w_data_ok    = i_in_valid && !i_in_break;
    assign w_pop        = i_pop && !w_empty;
    assign w_push       = w_data_ok && (!w_full || i_pop) && !i_flush;
    assign w_drop       = w_data_ok && w_full && !i_pop && !i_flush;
    assign w_break_rise = i_in_break && !r_break_prev;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (i_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
    end

    assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
            r_break_prev <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            // Set events take priority over a same-cycle clear.
            r_overrun    <= w_drop || (r_overrun && !i_stat_clr);
            r_break_det  <= w_break_rise || (r_break_det && !i_stat_clr);
            r_break_prev <= i_in_break;
            r_irq        <= (i_thresh != '0) && (w_count_nxt >= i_thresh);
        end
    end

    uart_fifo_mem #(
        .DEPTH     (DEPTH),
        .DATA_BITS (DATA_BITS),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign o_out_valid = !w_empty;
    assign o_out_data  = w_empty ? '0 : w_rdata;
    assign o_count     = w_count;
    assign o_full      = w_full;
    assign o_overrun   = r_overrun;
    assign o_break_det = r_break_det;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, overflow, full push+pop, break,
// threshold interrupt, flush and asynchronous reset.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_break;
    logic          pop;
    logic          flush;
    logic          stat_clr;
    logic [AW:0]   thresh;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [AW:0]   count;
    logic          full;
    logic          overrun;
    logic          break_det;
    logic          irq;

    int n_total = 0;
    int n_bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_BITS(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .i_in_break  (in_break),
        .i_pop       (pop),
        .i_flush     (flush),
        .i_stat_clr  (stat_clr),
        .i_thresh    (thresh),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_count     (count),
        .o_full      (full),
        .o_overrun   (overrun),
        .o_break_det (break_det),
        .o_irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},   32'(count),     32'd0);
        check({tag, "_valid"},   32'(out_valid), 32'd0);
        check({tag, "_data"},    32'(out_data),  32'd0);
        check({tag, "_full"},    32'(full),      32'd0);
        check({tag, "_overrun"}, 32'(overrun),   32'd0);
        check({tag, "_brk"},     32'(break_det), 32'd0);
        check({tag, "_irq"},     32'(irq),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_break = 1'b0;
        pop = 1'b0; flush = 1'b0; stat_clr = 1'b0; thresh = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // In-order delivery with one-cycle push latency
        push(8'h41);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_count", 32'(count), 32'd1);
        check("lat_head", 32'(out_data), 32'h41);
        push(8'h42);
        push(8'h43);
        check("abc_count", 32'(count), 32'd3);
        pop_chk("pop41", 8'h41);
        pop_chk("pop42", 8'h42);
        pop_chk("pop43", 8'h43);
        check("abc_empty_valid", 32'(out_valid), 32'd0);
        check("abc_empty_data", 32'(out_data), 32'd0);
        check("abc_empty_count", 32'(count), 32'd0);

        // Pop while empty is ignored
        pop = 1'b1; step(); pop = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_ovr", 32'(overrun), 32'd0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        check("full_ovr_pre", 32'(overrun), 32'd0);
        push(8'hAA);
        check("drop_ovr", 32'(overrun), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        check("drop_head", 32'(out_data), 32'h00);
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check("clr_ovr", 32'(overrun), 32'd0);

        // Push and pop together while full reuses the freed slot
        in_valid = 1'b1; in_data = 8'h55; pop = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; pop = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovr", 32'(overrun), 32'd0);
        check("pp_head", 32'(out_data), 32'h01);
        for (int i = 0; i < DEPTH; i++) begin
            pop_chk($sformatf("drain%0d", i), exp_q.pop_front());
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_ovr", 32'(overrun), 32'd0);

        // Break: byte during break is not stored, flag one cycle later
        in_break = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        check("brk_pre", 32'(break_det), 32'd0);
        step();
        in_valid = 1'b0;
        check("brk_count", 32'(count), 32'd0);
        check("brk_det", 32'(break_det), 32'd1);
        in_break = 1'b0;
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check("brk_clr", 32'(break_det), 32'd0);
        in_break = 1'b1; stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("brk_set_wins", 32'(break_det), 32'd1);
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check("brk_held_clr", 32'(break_det), 32'd0);
        in_break = 1'b0;
        step();

        // Threshold interrupt
        thresh = 5'd4;
        push(8'h01); push(8'h02); push(8'h03);
        check("irq_3", 32'(irq), 32'd0);
        push(8'h04);
        check("irq_4", 32'(irq), 32'd1);
        check("irq_4_count", 32'(count), 32'd4);
        pop_chk("irq_pop", 8'h01);
        check("irq_after_pop", 32'(irq), 32'd0);
        for (int i = 0; i < 13; i++) push(8'h10 + 8'(i));
        check("irq_16_count", 32'(count), 32'd16);
        check("irq_16", 32'(irq), 32'd1);
        thresh = 5'd0;
        step();
        check("irq_disabled", 32'(irq), 32'd0);

        // Flush: empties the FIFO, drops the coincident byte, keeps flags
        push(8'h99);
        check("pre_flush_ovr", 32'(overrun), 32'd1);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush1_count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        check("hold5_count", 32'(count), 32'd5);
        check("hold5_head", 32'(out_data), 32'h60);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data", 32'(out_data), 32'd0);
        check("flush_ovr", 32'(overrun), 32'd1);
        push(8'h21);
        check("post_flush_head", 32'(out_data), 32'h21);

        // Asynchronous reset mid-stream
        in_break = 1'b1; thresh = 5'd1;
        push(8'h22);
        check("pre_rst_brk", 32'(break_det), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        in_break = 1'b0; thresh = '0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_release_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART bit-level receiver and the memory-mapped UART controller. Captures each single-cycle received-byte pulse into a first-word-fall-through FIFO so software can tolerate read latency at high baud rates. Also provides overrun and break status flags and a level-threshold interrupt. The controller pops one byte per RX-data register read.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- DATA_BITS, 8, byte width; matches receiver payload width
- AW, $clog2(DEPTH), local; pointer index width; count is AW+1 bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  one-cycle pulse from receiver: in_data holds a new byte
- in_data  in  DATA_BITS  received byte
- in_break  in  1  level from receiver: line held in break
- pop  in  1  one-cycle read strobe from controller (RX-data read)
- flush  in  1  discard all contents, synchronous
- stat_clr  in  1  clear sticky overrun and break_det
- thresh  in  AW+1  interrupt level; 0 disables irq
- out_data  out  DATA_BITS  head entry; 0 when empty
- out_valid  out  1  FIFO not empty
- count  out  AW+1  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- overrun  out  1  sticky: a byte was dropped
- break_det  out  1  sticky: rising edge of in_break seen
- irq  out  1  registered: thresh != 0 && count >= thresh

## Operation
- Storage is a register array, not reset. Write pointer and read pointer are AW+1 bits and wrap naturally.
- Index = ptr[AW-1:0]; count = wr_ptr − rd_ptr; full when count == DEPTH; empty when the pointers are equal.
- **Push:**
  - Occurs when in_valid && !in_break && (!full || pop).
  - Writes mem[wr_ptr] and increments wr_ptr.
  - A push while full together with a pop is accepted: the slot freed by the pop is reused.
- **Drop:**
  - Occurs when in_valid && !in_break && full && !pop.
  - The byte is discarded, FIFO contents are unchanged, and overrun is set.
- in_valid while in_break is high never stores a byte; the break character is not data.
- **Pop:**
  - Occurs when pop && out_valid; increments rd_ptr.
  - pop while empty is ignored: no pointer change, no flag.
- Push and pop in the same cycle leave count unchanged.
- **break_det:** set on a cycle where in_break == 1 and the registered previous in_break == 0.
- **stat_clr:** clears overrun and break_det. A set event in the same cycle wins; the flag reads 1 afterwards.
- **flush:** sets rd_ptr = wr_ptr = 0. It wins over push and pop in the same cycle, so that byte is lost, but does not set overrun. Flags are unaffected.
- out_data = mem[rd_ptr index] when out_valid, else 0. Combinational from registered state.
- No state machine beyond the pointers; every output is a function of registered state except out_data's array read.

## Timing
- **Reset values:** pointers 0, out_valid 0, out_data 0, count 0, full 0, overrun 0, break_det 0, irq 0, previous-break register 0.
- **Push latency:** a byte accepted at edge N is visible on out_data/out_valid/count in cycle N+1.
- **Pop:** the next entry is presented in the cycle after the pop edge. The controller samples out_data during the pop cycle.
- irq is registered from the next-state count, so it changes in the same cycle as count.
- break_det asserts one cycle after in_break rises.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous) and clears all flags.
- Sustained push on every cycle is supported; the receiver guarantees in_valid ≤ 1 per byte time.

## Structure
- The shared UART header holds:
  - default DEPTH
  - RX-control status bit positions (valid/empty, overrun, break, irq) used by the controller
- One sub-module, uart_fifo_mem: a DEPTH × DATA_BITS register array with one synchronous write port and one asynchronous read port.
- Pointer, flag and irq logic live in uart_rx_fifo.

## Test plan
- Push 0x41, 0x42, 0x43 one cycle apart, then pop three times → out_data 0x41, 0x42, 0x43 in order; then out_valid 0, out_data 0, count 0.
- Push 16 bytes 0x00..0x0F, then push 0xAA without pop → full 1, count 16, overrun 1, head 0x00, 0xAA never read; stat_clr → overrun 0.
- With full, push 0x55 and pop in the same cycle → count stays 16; after 16 pops the last byte read is 0x55; overrun stays 0.
- Raise in_break with in_valid pulsed, data 0x00 → count unchanged, break_det 1 next cycle; stat_clr in the same cycle as a new in_break rise → break_det stays 1.
- thresh = 4: push 3 → irq 0; push 4th → irq 1 with count 4; pop 1 → irq 0; thresh = 0 with count 16 → irq 0.
- Hold 5 entries, then flush coincident with in_valid 0x77 → count 0, out_valid 0, overrun unchanged; assert rst_n low mid-stream → all outputs 0 asynchronously.
